// File: rtl/systolic_host_sequencer_if.sv
// Host-side job and result channels of the systolic host sequencer.
// The host drives the master modport, and the sequencer uses the slave modport.
interface systolic_host_sequencer_if #(
  parameter int unsigned ACT_LEN = 3
);
  logic                   job_valid;
  logic                   job_ready;
  logic [31:0]            job_weights;
  logic [31:0]            job_biases;
  logic [8*ACT_LEN-1:0]   job_acts;
  logic                   res_valid;
  logic                   res_ready;
  logic [15:0]            res_data;
  logic                   res_overrun;

  modport master (
    output job_valid, job_weights, job_biases, job_acts, res_ready,
    input  job_ready, res_valid, res_data, res_overrun
  );

  modport slave (
    input  job_valid, job_weights, job_biases, job_acts, res_ready,
    output job_ready, res_valid, res_data, res_overrun
  );
endinterface

// File: rtl/systolic_host_sequencer.sv
// Replays the array controller's frame schedule on the 8-bit pin bus from a queued job,
// then captures the drained 16-bit result into a one-entry buffer.
module systolic_host_sequencer #(
  parameter int unsigned FRAME_LEN  = 17,
  parameter int unsigned W_START    = 1,
  parameter int unsigned B_START    = 5,
  parameter int unsigned B_LEN      = 8,
  parameter int unsigned C_START    = 13,
  parameter int unsigned ACT_LEN    = 3,
  parameter int unsigned RES_OFFSET = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  systolic_host_sequencer_if.slave   host,
  output logic [7:0]                 pin_data_out,
  input  logic [15:0]                pin_res_in,
  output logic                       busy,
  output logic                       frame_start
);
  localparam int unsigned CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_OFF = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] RES_OFF  = CW'(RES_OFFSET);

  logic [CW-1:0]        frame_cnt, next_cnt;
  logic                 job_full, active, next_active;
  logic                 wrap, accept, capture;
  logic [31:0]          job_w, job_b, act_w, act_b, src_w, src_b;
  logic [8*ACT_LEN-1:0] job_a, act_a, src_a;
  logic [7:0]           next_byte;
  logic                 res_valid, res_overrun;
  logic [15:0]          res_data;
  int unsigned          next_off;

  always_comb begin
    wrap        = (frame_cnt == LAST_OFF);
    next_cnt    = wrap ? '0 : frame_cnt + CW'(1);
    next_active = wrap ? job_full : active;
    accept      = host.job_valid && !job_full;
    capture     = active && (frame_cnt == RES_OFF);
    src_w       = (wrap && job_full) ? job_w : act_w;
    src_b       = (wrap && job_full) ? job_b : act_b;
    src_a       = (wrap && job_full) ? job_a : act_a;
    next_off    = 32'(next_cnt);
    next_byte   = '0;
    // The byte is looked up one offset ahead, so the register holds it during that offset.
    if (next_active) begin
      for (int unsigned k = 0; k < 4; k++)
        if (next_off == W_START + k) next_byte = src_w[8*k +: 8];
      for (int unsigned k = 0; k < B_LEN; k++)
        if (next_off == B_START + k) next_byte = src_b[8*(k%4) +: 8];
      for (int unsigned k = 0; k < ACT_LEN; k++)
        if (next_off == C_START + k) next_byte = src_a[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      job_full     <= 1'b0;
      active       <= 1'b0;
      job_w        <= '0;
      job_b        <= '0;
      job_a        <= '0;
      act_w        <= '0;
      act_b        <= '0;
      act_a        <= '0;
      pin_data_out <= '0;
    end else begin
      frame_cnt    <= next_cnt;
      active       <= next_active;
      pin_data_out <= next_byte;
      if (wrap && job_full) begin
        act_w    <= job_w;
        act_b    <= job_b;
        act_a    <= job_a;
        job_full <= 1'b0;
      end
      // A job can only be accepted while the job register is empty.
      if (accept) begin
        job_w    <= host.job_weights;
        job_b    <= host.job_biases;
        job_a    <= host.job_acts;
        job_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_overrun <= 1'b0;
    end else if (capture) begin
      if (!res_valid || host.res_ready) begin
        res_data  <= pin_res_in;
        res_valid <= 1'b1;
      end else begin
        res_overrun <= 1'b1;
      end
    end else if (res_valid && host.res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign host.job_ready   = !job_full;
  assign host.res_valid   = res_valid;
  assign host.res_data    = res_data;
  assign host.res_overrun = res_overrun;
  assign busy             = active;
  assign frame_start      = (frame_cnt == '0);
endmodule

// File: tb/tb_systolic_host_sequencer.sv
// Randomized and directed checks of systolic_host_sequencer against a frame-level behavioural model.
module tb_systolic_host_sequencer;
  localparam int FRAME_LEN = 17;
  localparam int ACT_LEN   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pin_data_out;
  logic [15:0] pin_res_in = '0;
  logic        busy, frame_start;

  systolic_host_sequencer_if #(.ACT_LEN(ACT_LEN)) bus ();

  systolic_host_sequencer #(
    .FRAME_LEN(17), .W_START(1), .B_START(5), .B_LEN(8),
    .C_START(13), .ACT_LEN(ACT_LEN), .RES_OFFSET(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(bus),
    .pin_data_out(pin_data_out),
    .pin_res_in(pin_res_in),
    .busy(busy),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int c = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Byte the schedule puts on the pins at a given frame offset.
  function automatic logic [7:0] exp_byte(int o, logic [31:0] w, logic [31:0] b, logic [23:0] a);
    if (o >= 1 && o <= 4)   return w[8*(o-1) +: 8];
    if (o >= 5 && o <= 12)  return b[8*((o-5)%4) +: 8];
    if (o >= 13 && o <= 15) return a[8*(o-13) +: 8];
    return 8'h00;
  endfunction

  // Frame-level model: a one-deep job queue, the job owning the current frame, and a result buffer.
  int          m_cyc = 0;
  bit          m_held = 0, m_act = 0, m_rv = 0, m_ov = 0;
  logic [31:0] m_hw = '0, m_hb = '0, m_aw = '0, m_ab = '0;
  logic [23:0] m_ha = '0, m_aa = '0;
  logic [15:0] m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_held <= 0; m_act <= 0; m_rv <= 0; m_ov <= 0; m_rd <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc % FRAME_LEN == FRAME_LEN - 1) begin
        if (m_act) begin
          if (!m_rv || bus.res_ready) begin
            m_rd <= pin_res_in;
            m_rv <= 1;
          end else begin
            m_ov <= 1;
          end
        end else if (m_rv && bus.res_ready) begin
          m_rv <= 0;
        end
        m_act <= m_held;
        if (m_held) begin
          m_aw <= m_hw; m_ab <= m_hb; m_aa <= m_ha; m_held <= 0;
        end
      end else if (m_rv && bus.res_ready) begin
        m_rv <= 0;
      end
      if (bus.job_valid && !m_held) begin
        m_held <= 1;
        m_hw <= bus.job_weights; m_hb <= bus.job_biases; m_ha <= bus.job_acts;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("frame_start", 32'(frame_start), 32'(m_cyc % FRAME_LEN == 0));
    check("busy", 32'(busy), 32'(m_act));
    check("job_ready", 32'(bus.job_ready), 32'(!m_held));
    check("pin_data_out", 32'(pin_data_out),
          32'(m_act ? exp_byte(m_cyc % FRAME_LEN, m_aw, m_ab, m_aa) : 8'h00));
    check("res_valid", 32'(bus.res_valid), 32'(m_rv));
    check("res_data", 32'(bus.res_data), 32'(m_rd));
    check("res_overrun", 32'(bus.res_overrun), 32'(m_ov));
  end

  task automatic next_cycle();
    @(negedge clk);
    c++;
  endtask

  task automatic drive_idle();
    bus.job_valid = 0; bus.job_weights = '0; bus.job_biases = '0; bus.job_acts = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
    c = 0;
  endtask

  task automatic offer(logic [31:0] w, logic [31:0] b, logic [23:0] a);
    bus.job_valid = 1; bus.job_weights = w; bus.job_biases = b; bus.job_acts = a;
  endtask

  logic [7:0] tbl [16] = '{8'h01, 8'h02, 8'h03, 8'h04,
                           8'h10, 8'h20, 8'h30, 8'h40, 8'h10, 8'h20, 8'h30, 8'h40,
                           8'h0A, 8'h0B, 8'h0C, 8'h00};

  initial begin
    drive_idle();
    bus.res_ready = 1;

    check("model_weight", 32'(exp_byte(3, 32'h04030201, '0, '0)), 32'h03);
    check("model_bias", 32'(exp_byte(11, '0, 32'h40302010, '0)), 32'h30);

    // Single job accepted in frame 0.
    do_reset();
    check("reset_job_ready", 32'(bus.job_ready), 32'h1);
    check("reset_frame_start", 32'(frame_start), 32'h1);
    pin_res_in = 16'hBEEF;
    offer(32'h04030201, 32'h40302010, 24'h0C0B0A);
    next_cycle();
    bus.job_valid = 0;
    check("single_held", 32'(bus.job_ready), 32'h0);
    while (c < 34) begin
      next_cycle();
      if (c >= 18 && c <= 33) check("single_pin", 32'(pin_data_out), 32'(tbl[c-18]));
    end
    check("single_res_valid", 32'(bus.res_valid), 32'h1);
    check("single_res_data", 32'(bus.res_data), 32'hBEEF);

    // Idle frames.
    repeat (3 * FRAME_LEN) next_cycle();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_res_valid", 32'(bus.res_valid), 32'h0);

    // Mid-frame reset with a held job.
    offer(32'hAABBCCDD, 32'h11223344, 24'h556677);
    next_cycle();
    check("held_before_reset", 32'(bus.job_ready), 32'h0);
    rst_n = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
    c = 0;
    check("rst_job_ready", 32'(bus.job_ready), 32'h1);
    check("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_pin", 32'(pin_data_out), 32'h00);
    check("rst_frame_start", 32'(frame_start), 32'h1);

    // Back-to-back then overrun, same stimulus with res_ready high then low.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      bus.res_ready = (pass == 0);
      pin_res_in = 16'h1111;
      offer(32'h0D0C0B0A, 32'h1A2B3C4D, 24'h777777);
      next_cycle();
      check("b2b_held_a", 32'(bus.job_ready), 32'h0);
      offer(32'h99887766, 32'h55443322, 24'h123456);
      while (c < 17) next_cycle();
      check("b2b_ready_gap", 32'(bus.job_ready), 32'h1);
      next_cycle();
      check("b2b_held_b", 32'(bus.job_ready), 32'h0);
      drive_idle();
      while (c < 34) next_cycle();
      pin_res_in = 16'h2222;
      check("res_a_valid", 32'(bus.res_valid), 32'h1);
      check("res_a_data", 32'(bus.res_data), 32'h1111);
      check("res_a_overrun", 32'(bus.res_overrun), 32'h0);
      while (c < 51) next_cycle();
      check("res_b_valid", 32'(bus.res_valid), 32'h1);
      check("res_b_data", 32'(bus.res_data), pass == 0 ? 32'h2222 : 32'h1111);
      check("res_b_overrun", 32'(bus.res_overrun), 32'(pass));
      bus.res_ready = 1;
      next_cycle();
      check("res_drain_valid", 32'(bus.res_valid), 32'h0);
      check("res_drain_overrun", 32'(bus.res_overrun), 32'(pass));
    end

    // Random traffic with occasional mid-frame resets.
    do_reset();
    repeat (1500) begin
      next_cycle();
      if ($urandom_range(299) == 0) begin
        rst_n = 0;
        drive_idle();
        repeat ($urandom_range(2, 1)) @(negedge clk);
        rst_n = 1;
      end
      bus.job_valid   = 1'($urandom_range(1));
      bus.job_weights = $urandom;
      bus.job_biases  = $urandom;
      bus.job_acts    = 24'($urandom);
      bus.res_ready   = ($urandom_range(9) < 7);
      pin_res_in      = 16'($urandom);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
